lmc_control: RTL and testbench
==============================

// Module: lmc_control
// PURPOSE
//  Fetch/decode/execute sequencer for the Little Man Computer. Sole master of the 100-word
//  decimal memory: drives addr/data/write_enable and consumes its combinational read port.
//  Holds PC, IR, ACC and the negative flag. Talks to the outside world via valid/ready INP/OUT.
// PARAMETERS
//  ADDR_W     7    memory address width
//  DATA_W     11   memory word width; legal word values are 0..999
//  MEM_WORDS  100  memory depth; the PC wraps modulo this value
// PORTS
//  clk        in   1       single clock; all state updates on its rising edge
//  reset      in   1       synchronous, active-high; resets every register below
//  start      in   1       in S_IDLE, a 1 begins execution at PC=0
//  mem_addr   out  ADDR_W  to memory addr
//  mem_wdata  out  DATA_W  to memory data (always ACC)
//  mem_we     out  1       to memory write_enable
//  mem_rdata  in   DATA_W  memory out; combinational for the current mem_addr
//  in_data    in   DATA_W  INP value
//  in_valid   in   1       in_data valid
//  in_ready   out  1       controller is executing INP
//  out_data   out  DATA_W  OUT value (=ACC)
//  out_valid  out  1       controller is executing OUT
//  out_ready  in   1       sink accepts out_data
//  halted     out  1       in S_HALT
//  illegal    out  1       halted on an illegal word; sticky until reset
//  pc         out  ADDR_W  debug: program counter
//  acc        out  DATA_W  debug: accumulator
// BEHAVIOUR
//  Reset values: state=S_IDLE, PC=0, IR=0, ACC=0, neg=0, illegal=0. All strobes are 0.
//  States: S_IDLE -> (start) S_FETCH -> S_EXEC -> S_FETCH ...; S_EXEC -> S_HALT on HLT or illegal.
//  S_HALT is left only by reset.
//  S_FETCH:
//   - mem_addr=PC; IR<=mem_rdata; PC<=(PC==MEM_WORDS-1)?0:PC+1.
//  S_EXEC: opcode=IR/100, operand=IR%100, mem_addr=operand. Each instruction takes 2 cycles
//  unless it stalls.
//   1xx ADD: ACC<=(ACC+m)%1000; neg<=0.
//   2xx SUB: ACC<=ACC-m, or ACC-m+1000 if ACC<m; neg<=(ACC<m).
//   3xx STA: mem_we=1 for exactly this cycle; mem_wdata=ACC.
//   5xx LDA: ACC<=m; neg<=0.
//   6xx BRA: PC<=operand.
//   7xx BRZ: PC<=operand if ACC==0 (neg ignored).
//   8xx BRP: PC<=operand if neg==0.
//   901 INP: in_ready=1; stay in S_EXEC until in_valid. On the handshake ACC<=in_data, neg<=0.
//   902 OUT: out_valid=1; out_data=ACC; stay in S_EXEC until out_ready. Both handshakes are
//   same-cycle; ACC and out_data stay stable while stalled.
//   000 HLT: -> S_HALT.
//  Illegal -> S_HALT, illegal<=1, PC unchanged (it addresses the next word). Illegal means:
//   - fetched IR>999;
//   - opcode 4;
//   - opcode 9 with operand other than 01/02;
//   - 0xx with xx!=0;
//   - ADD/SUB/LDA operand m>999;
//   - INP with in_data>999 (checked at the handshake; the value is not loaded).
//  Outside S_EXEC, mem_we, in_ready and out_valid are 0. In S_IDLE/S_HALT, mem_addr=PC.
//  Reset asserted at any point (including mid-stall) wins; the handshake in that cycle is dropped.
//  No combinational path from in_valid/out_ready to in_ready/out_valid.
// STRUCTURE
//  lmc_pkg:
//   - state_t enum {S_IDLE,S_FETCH,S_EXEC,S_HALT}
//   - opcode localparams OP_HLT..OP_IO
//   - IO_INP=1, IO_OUT=2, LMC_MAX=999
//   - function lmc_decode(word) -> {opcode, operand, legal}
//  Sub-module lmc_alu (combinational): ACC, m, op -> {result, neg}; implements the mod-1000
//  ADD/SUB rules.
//  FSM, PC/IR/ACC registers and handshake logic live in lmc_control.
// TESTING (bench pairs this block with the memory; preload via reset, then overwrite with
// writes as needed)
//  1 Program 901,902,000. start, in_data=42 with in_valid held low for 3 cycles:
//    in_ready holds for 4 cycles; then out_data=42, out_valid held until out_ready;
//    then halted=1, illegal=0.
//  2 ACC=700, ADD of a word 400: ACC=100, neg=0. SUB 5-7: ACC=998, neg=1; a following BRP
//    is not taken; BRZ with ACC=0 is taken.
//  3 STA 350 with ACC=123: mem_we pulses exactly 1 cycle with addr 50, data 123; a
//    following LDA 50 gives ACC=123.
//  4 Word 600 at address 99 with PC=99: the fetch wraps PC to 0, BRA sets PC=0, and the
//    loop repeats with no X values.
//  5 Illegal cases: word 400 at address 3 -> halted=1, illegal=1, pc=4. Also cover 905,
//    an IR of 1500, and in_data=1000.
//  6 Reset asserted during an out_valid stall -> next cycle S_IDLE, pc=0, acc=0, out_valid=0.
//    The program reruns correctly after start.

Source files
------------

// File: rtl/lmc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lmc_pkg                                                      |
// | Description : Shared types, opcode constants and instruction decoder for   |
// |               the Little Man Computer controller.                          |
// |               Contents: state_t, OP_* opcodes, IO_INP/IO_OUT, LMC_MAX,     |
// |               decode_t and lmc_decode().                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package lmc_pkg;

   localparam int LMC_DATA_W = 11;

   localparam logic [3:0] OP_HLT = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_STA = 4'd3;
   localparam logic [3:0] OP_LDA = 4'd5;
   localparam logic [3:0] OP_BRA = 4'd6;
   localparam logic [3:0] OP_BRZ = 4'd7;
   localparam logic [3:0] OP_BRP = 4'd8;
   localparam logic [3:0] OP_IO  = 4'd9;

   localparam logic [6:0] IO_INP = 7'd1;
   localparam logic [6:0] IO_OUT = 7'd2;

   localparam logic [LMC_DATA_W-1:0] LMC_MAX = 11'd999;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   typedef struct packed {
      logic [3:0] opcode;
      logic [6:0] operand;
      logic       legal;
   } decode_t;

   // Splits a decimal word into opcode (hundreds) and operand (tens/units) and
   // flags every encoding that has no defined meaning. Operand-value checks
   // (memory word or INP value out of range) happen at execute time.
   function automatic decode_t lmc_decode(input logic [LMC_DATA_W-1:0] word);
      decode_t d;
      d.opcode  = 4'(word / 11'd100);
      d.operand = 7'(word % 11'd100);
      d.legal   = (word <= LMC_MAX)
                  && (d.opcode != 4'd4)
                  && !((d.opcode == OP_IO) && (d.operand != IO_INP) && (d.operand != IO_OUT))
                  && !((d.opcode == OP_HLT) && (d.operand != 7'd0));
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lmc_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lmc_alu                                                      |
// | Description : Combinational decimal ALU. ADD wraps modulo 1000; SUB        |
// |               borrows by adding 1000 and raises the negative flag.         |
// |               Ports: i_acc, i_m (operands 0..999), i_sub (1=SUB, 0=ADD),   |
// |               o_result (0..999), o_neg.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lmc_alu #(
   parameter int DATA_W = 11
) (
   input  logic [DATA_W-1:0] i_acc,
   input  logic [DATA_W-1:0] i_m,
   input  logic              i_sub,
   output logic [DATA_W-1:0] o_result,
   output logic              o_neg
);

   localparam logic [DATA_W-1:0] c_mod = DATA_W'(1000);

   logic [DATA_W-1:0] w_sum;
   logic              w_borrow;

   // Operands never exceed 999, so ACC+m (<=1998) and ACC+1000-m fit DATA_W.
   assign w_sum    = i_acc + i_m;
   assign w_borrow = (i_acc < i_m);

   always_comb begin
      o_result = '0;
      o_neg    = 1'b0;
      if (i_sub) begin
         o_neg    = w_borrow;
         o_result = w_borrow ? (i_acc + c_mod - i_m) : (i_acc - i_m);
      end else begin
         o_result = (w_sum >= c_mod) ? (w_sum - c_mod) : w_sum;
      end
   end

endmodule
`default_nettype wire

// File: rtl/lmc_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lmc_control                                                  |
// | Description : Fetch/decode/execute sequencer for the Little Man Computer.  |
// |               Sole master of the 100-word memory; holds PC, IR, ACC, neg.  |
// |               Ports: clk, reset (sync, active-high), i_start;              |
// |               memory o_mem_addr/o_mem_wdata/o_mem_we/i_mem_rdata;          |
// |               INP i_in_data/i_in_valid/o_in_ready;                         |
// |               OUT o_out_data/o_out_valid/i_out_ready;                      |
// |               status o_halted/o_illegal; debug o_pc/o_acc.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lmc_control
   import lmc_pkg::*;
#(
   parameter int ADDR_W    = 7,
   parameter int DATA_W    = 11,
   parameter int MEM_WORDS = 100
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_mem_we,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic              o_halted,
   output logic              o_illegal,
   output logic [ADDR_W-1:0] o_pc,
   output logic [DATA_W-1:0] o_acc
);

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, w_pc_nxt;
   logic [DATA_W-1:0] r_ir, w_ir_nxt;
   logic [DATA_W-1:0] r_acc, w_acc_nxt;
   logic              r_neg, w_neg_nxt;
   logic              r_illegal, w_illegal_nxt;

   decode_t           w_dec;
   logic [ADDR_W-1:0] w_operand;
   logic [DATA_W-1:0] w_alu_result;
   logic              w_alu_neg;
   logic              w_m_ok;
   logic              w_in_ok;

   assign w_dec     = lmc_decode(LMC_DATA_W'(r_ir));
   assign w_operand = ADDR_W'(w_dec.operand);
   assign w_m_ok    = (i_mem_rdata <= DATA_W'(LMC_MAX));
   assign w_in_ok   = (i_in_data <= DATA_W'(LMC_MAX));

   lmc_alu #(
      .DATA_W   (DATA_W)
   ) u_alu (
      .i_acc    (r_acc),
      .i_m      (i_mem_rdata),
      .i_sub    (w_dec.opcode == OP_SUB),
      .o_result (w_alu_result),
      .o_neg    (w_alu_neg)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_pc      <= '0;
         r_ir      <= '0;
         r_acc     <= '0;
         r_neg     <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_ir      <= w_ir_nxt;
         r_acc     <= w_acc_nxt;
         r_neg     <= w_neg_nxt;
         r_illegal <= w_illegal_nxt;
      end
   end

   // Strobes depend only on state and IR, never on i_in_valid/i_out_ready.
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_ir_nxt      = r_ir;
      w_acc_nxt     = r_acc;
      w_neg_nxt     = r_neg;
      w_illegal_nxt = r_illegal;
      o_mem_addr    = r_pc;
      o_mem_we      = 1'b0;
      o_in_ready    = 1'b0;
      o_out_valid   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (i_start) w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            w_ir_nxt    = i_mem_rdata;
            w_pc_nxt    = (r_pc == ADDR_W'(MEM_WORDS - 1)) ? '0 : r_pc + 1'b1;
            w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            o_mem_addr  = w_operand;
            w_state_nxt = S_FETCH;
            if (!w_dec.legal) begin
               w_state_nxt   = S_HALT;
               w_illegal_nxt = 1'b1;
            end else begin
               case (w_dec.opcode)
                  OP_HLT: w_state_nxt = S_HALT;
                  OP_ADD, OP_SUB: begin
                     if (w_m_ok) begin
                        w_acc_nxt = w_alu_result;
                        w_neg_nxt = w_alu_neg;
                     end else begin
                        w_state_nxt   = S_HALT;
                        w_illegal_nxt = 1'b1;
                     end
                  end
                  OP_STA: o_mem_we = 1'b1;
                  OP_LDA: begin
                     if (w_m_ok) begin
                        w_acc_nxt = i_mem_rdata;
                        w_neg_nxt = 1'b0;
                     end else begin
                        w_state_nxt   = S_HALT;
                        w_illegal_nxt = 1'b1;
                     end
                  end
                  OP_BRA: w_pc_nxt = w_operand;
                  OP_BRZ: if (r_acc == '0) w_pc_nxt = w_operand;
                  OP_BRP: if (!r_neg) w_pc_nxt = w_operand;
                  OP_IO: begin
                     if (w_dec.operand == IO_INP) begin
                        o_in_ready  = 1'b1;
                        w_state_nxt = S_EXEC;
                        if (i_in_valid) begin
                           if (w_in_ok) begin
                              w_acc_nxt   = i_in_data;
                              w_neg_nxt   = 1'b0;
                              w_state_nxt = S_FETCH;
                           end else begin
                              w_state_nxt   = S_HALT;
                              w_illegal_nxt = 1'b1;
                           end
                        end
                     end else begin
                        o_out_valid = 1'b1;
                        w_state_nxt = i_out_ready ? S_FETCH : S_EXEC;
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_HALT: ;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign o_mem_wdata = r_acc;
   assign o_out_data  = r_acc;
   assign o_halted    = (r_state == S_HALT);
   assign o_illegal   = r_illegal;
   assign o_pc        = r_pc;
   assign o_acc       = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_lmc_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lmc_control                                               |
// | Description : Directed self-checking bench for lmc_control with a local    |
// |               100-word memory model (combinational read, clocked write).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lmc_control;

   logic        clk;
   logic        reset;
   logic        start;
   logic [6:0]  mem_addr;
   logic [10:0] mem_wdata;
   logic        mem_we;
   logic [10:0] mem_rdata;
   logic [10:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        halted;
   logic        illegal;
   logic [6:0]  pc;
   logic [10:0] acc;

   logic [10:0] mem [0:127];
   logic        tb_we;
   logic [6:0]  tb_waddr;
   logic [10:0] tb_wdata;

   int checks   = 0;
   int failures = 0;

   lmc_control u_dut (
      .clk         (clk),
      .reset       (reset),
      .i_start     (start),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .o_mem_we    (mem_we),
      .i_mem_rdata (mem_rdata),
      .i_in_data   (in_data),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .o_out_data  (out_data),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_halted    (halted),
      .o_illegal   (illegal),
      .o_pc        (pc),
      .o_acc       (acc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: bench preload port has priority over the controller.
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (tb_we)       mem[tb_waddr] <= tb_wdata;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [6:0] a, input logic [10:0] d);
      tb_we    = 1'b1;
      tb_waddr = a;
      tb_wdata = d;
      tick();
      tb_we    = 1'b0;
   endtask

   // Holds reset while clearing memory; caller pokes the program, then releases.
   task automatic prep();
      reset = 1'b1;
      for (int i = 0; i < 128; i++) poke(7'(i), 11'd0);
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;

      // ---- 1: INP/OUT handshakes with stalls ----
      prep();
      poke(7'd0, 11'd901); poke(7'd1, 11'd902); poke(7'd2, 11'd0);
      reset = 1'b0;
      chk("rst_pc", 32'(pc), 0);
      chk("rst_acc", 32'(acc), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_illegal", 32'(illegal), 0);
      chk("rst_strobes", {29'd0, in_ready, out_valid, mem_we}, 0);
      chk("idle_addr", 32'(mem_addr), 0);
      go();
      chk("fetch_in_ready", 32'(in_ready), 0);
      tick();
      for (int c = 0; c < 3; c++) begin
         chk("inp_stall_ready", 32'(in_ready), 1);
         tick();
      end
      in_data = 11'd42; in_valid = 1'b1;
      chk("inp_ready_c4", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk("inp_acc", 32'(acc), 42);
      chk("inp_ready_drop", 32'(in_ready), 0);
      tick();
      chk("out_valid", 32'(out_valid), 1);
      chk("out_data", 32'(out_data), 42);
      tick();
      chk("out_stall_valid", 32'(out_valid), 1);
      chk("out_stall_data", 32'(out_data), 42);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("out_valid_drop", 32'(out_valid), 0);
      tick(); tick();
      chk("t1_halted", 32'(halted), 1);
      chk("t1_illegal", 32'(illegal), 0);
      chk("t1_pc", 32'(pc), 3);

      // ---- 2: ADD wrap, SUB borrow, BRP not taken, BRZ taken ----
      prep();
      poke(7'd0, 11'd520); poke(7'd1, 11'd121); poke(7'd2, 11'd522); poke(7'd3, 11'd223);
      poke(7'd4, 11'd810); poke(7'd5, 11'd224); poke(7'd6, 11'd712); poke(7'd7, 11'd400);
      poke(7'd10, 11'd400); poke(7'd12, 11'd0);
      poke(7'd20, 11'd700); poke(7'd21, 11'd400); poke(7'd22, 11'd5);
      poke(7'd23, 11'd7); poke(7'd24, 11'd998);
      reset = 1'b0;
      go();
      tick(); tick();
      chk("lda_700", 32'(acc), 700);
      tick(); tick();
      chk("add_wrap", 32'(acc), 100);
      tick(); tick(); tick(); tick();
      chk("sub_borrow", 32'(acc), 998);
      tick(); tick();
      chk("brp_not_taken", 32'(pc), 5);
      tick(); tick();
      chk("sub_zero", 32'(acc), 0);
      tick(); tick();
      chk("brz_taken", 32'(pc), 12);
      tick(); tick();
      chk("t2_halted", 32'(halted), 1);
      chk("t2_illegal", 32'(illegal), 0);

      // ---- 3: STA pulse then LDA of the stored word ----
      prep();
      poke(7'd0, 11'd510); poke(7'd1, 11'd350); poke(7'd2, 11'd511);
      poke(7'd3, 11'd550); poke(7'd4, 11'd0); poke(7'd10, 11'd123);
      reset = 1'b0;
      go();
      tick(); tick();
      chk("sta_pre_we", 32'(mem_we), 0);
      tick();
      chk("sta_we", 32'(mem_we), 1);
      chk("sta_addr", 32'(mem_addr), 50);
      chk("sta_data", 32'(mem_wdata), 123);
      tick();
      chk("sta_we_drop", 32'(mem_we), 0);
      chk("sta_mem", 32'(mem[50]), 123);
      tick(); tick();
      chk("lda_zero", 32'(acc), 0);
      tick(); tick();
      chk("lda_stored", 32'(acc), 123);

      // ---- 4: PC wrap at 99 and BRA loop ----
      prep();
      poke(7'd0, 11'd699); poke(7'd99, 11'd600);
      reset = 1'b0;
      go();
      for (int lp = 0; lp < 3; lp++) begin
         tick(); chk("loop_fetch0_pc", 32'(pc), 1);
         tick(); chk("loop_bra99_pc", 32'(pc), 99);
         chk("loop_fetch_addr", 32'(mem_addr), 99);
         tick(); chk("loop_wrap_pc", 32'(pc), 0);
         tick(); chk("loop_bra0_pc", 32'(pc), 0);
      end
      chk("loop_not_halted", 32'(halted), 0);

      // ---- 5: illegal cases ----
      prep();
      poke(7'd0, 11'd603); poke(7'd3, 11'd400);
      reset = 1'b0;
      go();
      tick(); tick(); tick(); tick();
      chk("op4_halted", 32'(halted), 1);
      chk("op4_illegal", 32'(illegal), 1);
      chk("op4_pc", 32'(pc), 4);
      tick(); tick();
      chk("op4_sticky", {30'd0, halted, illegal}, 3);

      prep();
      poke(7'd0, 11'd905);
      reset = 1'b0;
      go(); tick(); tick();
      chk("io905_illegal", {30'd0, halted, illegal}, 3);
      chk("io905_pc", 32'(pc), 1);

      prep();
      poke(7'd0, 11'd1500);
      reset = 1'b0;
      go(); tick(); tick();
      chk("ir1500_illegal", {30'd0, halted, illegal}, 3);
      chk("ir1500_pc", 32'(pc), 1);

      prep();
      poke(7'd0, 11'd105); poke(7'd5, 11'd1200);
      reset = 1'b0;
      go(); tick(); tick();
      chk("add_m_big_illegal", {30'd0, halted, illegal}, 3);
      chk("add_m_big_acc", 32'(acc), 0);

      prep();
      poke(7'd0, 11'd901);
      reset = 1'b0;
      go(); tick();
      in_data = 11'd1000; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("inp1000_illegal", {30'd0, halted, illegal}, 3);
      chk("inp1000_acc", 32'(acc), 0);
      chk("inp1000_pc", 32'(pc), 1);

      // ---- 6: reset during an OUT stall, then rerun ----
      prep();
      poke(7'd0, 11'd510); poke(7'd1, 11'd902); poke(7'd2, 11'd0); poke(7'd10, 11'd77);
      reset = 1'b0;
      go(); tick(); tick(); tick();
      chk("t6_out_valid", 32'(out_valid), 1);
      chk("t6_out_data", 32'(out_data), 77);
      tick();
      reset = 1'b1; out_ready = 1'b1;
      tick();
      reset = 1'b0; out_ready = 1'b0;
      chk("t6_rst_pc", 32'(pc), 0);
      chk("t6_rst_acc", 32'(acc), 0);
      chk("t6_rst_out_valid", 32'(out_valid), 0);
      chk("t6_rst_halted", 32'(halted), 0);
      tick();
      chk("t6_idle_pc", 32'(pc), 0);
      go(); tick(); tick(); tick();
      chk("t6_rerun_valid", 32'(out_valid), 1);
      chk("t6_rerun_data", 32'(out_data), 77);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t6_rerun_drop", 32'(out_valid), 0);
      tick(); tick();
      chk("t6_halted", {30'd0, halted, illegal}, 2);
      chk("t6_pc", 32'(pc), 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time bound so the run always ends on its own.
   initial begin
      #1000000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
